demux_fifo_arbiter: RTL and testbench
=====================================

# demux_fifo_arbiter

Downstream stage of the 1:4 class demultiplexer. It buffers each of the four class outputs (data plus valid) in its own FIFO. A round-robin arbiter drains the FIFOs into a single registered output stream with a pop handshake. The block absorbs bursts to any one class and reports per-class fill state and overflow back to the traffic source.

## Interface
- DATA_W, 12: word width; matches the demux data path.
- DEPTH, 4: entries per class FIFO; power of two, at least 2.
- AFULL_TH, 3: almost_full[n] asserts when count of FIFO n ≥ AFULL_TH; must satisfy 1 ≤ AFULL_TH ≤ DEPTH.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- data_in0..data_in3  in  DATA_W each  words from demux outputs 0..3.
- valid_in0..valid_in3  in  1 each  push request for FIFO 0..3.
- pop  in  1  downstream accepts the current output word this cycle.
- data_out  out  DATA_W  arbitrated word.
- class_out  out  2  index of the FIFO that supplied data_out.
- valid_out  out  1  data_out/class_out hold a word.
- almost_full  out  4  per-FIFO threshold flag.
- fifo_empty  out  4  per-FIFO count==0.
- overflow  out  4  sticky per-FIFO drop flag.

## Operation
- Each FIFO is a circular buffer with write pointer, read pointer and count of width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push: when valid_inN=1 at a clock edge and count<DEPTH, the word is written and count increments.
- Push into a full FIFO (count==DEPTH):
  - The word is dropped, even if the same FIFO is being read that cycle.
  - overflow[N] is set.
  - overflow bits clear only on reset.
- Output register: data_out, class_out and valid_out form a one-entry stage.
  - The stage is "free" when valid_out==0 or pop==1.
  - When free and at least one FIFO is non-empty, the arbiter grants one FIFO. The granted FIFO's head word is loaded, class_out is set to its index, valid_out is set to 1, and that FIFO's count decrements.
  - When free and all FIFOs are empty, valid_out is set to 0. data_out and class_out hold their previous values.
  - pop while valid_out==0 is ignored.
- Round-robin arbiter:
  - last_grant is 2 bits, reset value 3.
  - Search order is last_grant+1, +2, +3, +4 (mod 4). The first non-empty FIFO wins and last_grant updates to it.
  - last_grant is unchanged when there is no grant.
- Same-FIFO push and arbiter read in one cycle (count<DEPTH): both take effect, and count is unchanged.
  - If count==0 at that edge, there is no read: FIFO emptiness is evaluated on pre-edge count, with no bypass. Only the push happens.
- Flags almost_full and fifo_empty are combinational from the counts.

## Timing
- Reset (reset_L=0, asynchronous) forces:
  - data_out=0, class_out=0, valid_out=0.
  - All pointers and counts to 0; fifo_empty=4'b1111, almost_full=0.
  - overflow=0, last_grant=3.
- Minimum latency: a word with valid_in asserted before edge k is in the FIFO after edge k. It appears on data_out with valid_out=1 after edge k+1 (2-cycle path), provided the output stage is free and the word wins arbitration.
- Throughput: one word per cycle out while pop stays 1 and any FIFO is non-empty. Up to four words per cycle in.
- Outputs are stable between edges except the combinational flags.
- When reset_L is released, pushes are accepted at the first rising edge with reset_L=1.

## Test plan
- Reset check:
  - Hold reset_L=0 with valid_in0=1, data_in0=12'h5A5.
  - Required: valid_out=0, fifo_empty=1111, overflow=0 throughout, and nothing is stored.
- Single word:
  - After reset, push data_in0=1 for one cycle with pop=1.
  - Required: valid_out=1, data_out=1, class_out=0 two edges after the push edge. valid_out=0 on the next edge.
- Four-class burst:
  - One cycle with data 1,2,3,4 on inputs 0..3, pop held 1.
  - Required: outputs in order (1,c0),(2,c1),(3,c2),(4,c3) on consecutive cycles.
- Round-robin fairness:
  - Keep FIFOs 1 and 3 non-empty, pop=1.
  - Required: class_out alternates 1,3,1,3…
- Overflow:
  - With pop=0, push 5 words 10..14 into FIFO 2 on consecutive cycles.
  - Required: almost_full[2]=1 after 3rd push; overflow[2]=1 after 5th push.
  - Then popping yields 10,11,12,13 only, and overflow[2] stays 1.
- Backpressure and reset mid-stream:
  - With valid_out=1, hold pop=0 for 3 cycles. Required: data_out is unchanged.
  - Pulse reset_L low mid-cycle. Required: valid_out and counts go to 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/demux_fifo_arbiter.sv
// Four per-class FIFOs drained round-robin into a single registered output stage.
// Each FIFO reports fill flags and a sticky overflow flag back to the traffic source.
module demux_fifo_arbiter #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AFULL_TH = 3
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic              valid_in0,
  input  logic              valid_in1,
  input  logic              valid_in2,
  input  logic              valid_in3,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        class_out,
  output logic              valid_out,
  output logic [3:0]        almost_full,
  output logic [3:0]        fifo_empty,
  output logic [3:0]        overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_W-1:0] w_din [4];
  logic [3:0]        w_vin;
  logic [DATA_W-1:0] r_mem [4][DEPTH];
  logic [PW-1:0]     r_wptr [4];
  logic [PW-1:0]     r_rptr [4];
  logic [CW-1:0]     r_cnt  [4];
  logic [3:0]        r_ovf;
  logic [1:0]        r_last;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_class;
  logic              r_valid;

  logic [3:0]        w_full, w_nonempty, w_push, w_drop, w_rd;
  logic              w_free, w_gnt_vld;
  logic [1:0]        w_gnt_idx, w_cand;
  logic [DATA_W-1:0] w_head;

  assign w_din[0] = data_in0;
  assign w_din[1] = data_in1;
  assign w_din[2] = data_in2;
  assign w_din[3] = data_in3;
  assign w_vin    = {valid_in3, valid_in2, valid_in1, valid_in0};

  always_comb begin
    w_full      = '0;
    w_nonempty  = '0;
    almost_full = '0;
    for (int unsigned n = 0; n < 4; n++) begin
      w_full[n]      = (r_cnt[n] == CW'(DEPTH));
      w_nonempty[n]  = (r_cnt[n] != '0);
      almost_full[n] = (r_cnt[n] >= CW'(AFULL_TH));
    end
    // A full FIFO drops its push even when the arbiter reads it this cycle.
    w_push     = w_vin & ~w_full;
    w_drop     = w_vin & w_full;
    fifo_empty = ~w_nonempty;
  end

  assign w_free = !r_valid || pop;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = r_last;
    w_cand    = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      w_cand = r_last + 2'(k);
      if (!w_gnt_vld && w_nonempty[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    w_rd = (w_free && w_gnt_vld) ? (4'b0001 << w_gnt_idx) : '0;
  end

  assign w_head = r_mem[w_gnt_idx][r_rptr[w_gnt_idx]];

  always_ff @(posedge clk) begin
    for (int unsigned n = 0; n < 4; n++) begin
      if (w_push[n]) r_mem[n][r_wptr[n]] <= w_din[n];
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int unsigned n = 0; n < 4; n++) begin
        r_wptr[n] <= '0;
        r_rptr[n] <= '0;
        r_cnt[n]  <= '0;
      end
      r_ovf   <= '0;
      r_last  <= 2'd3;
      r_data  <= '0;
      r_class <= '0;
      r_valid <= 1'b0;
    end else begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (w_push[n]) r_wptr[n] <= r_wptr[n] + 1'b1;
        if (w_rd[n])   r_rptr[n] <= r_rptr[n] + 1'b1;
        r_cnt[n] <= r_cnt[n] + CW'(w_push[n]) - CW'(w_rd[n]);
      end
      r_ovf <= r_ovf | w_drop;
      if (w_free) begin
        if (w_gnt_vld) begin
          r_data  <= w_head;
          r_class <= w_gnt_idx;
          r_valid <= 1'b1;
          r_last  <= w_gnt_idx;
        end else begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign data_out  = r_data;
  assign class_out = r_class;
  assign valid_out = r_valid;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_demux_fifo_arbiter.sv
// Scoreboard bench: stimulus queues hand-computed {data,class} words; a negedge
// monitor pops and compares each word as the downstream accepts it.
module tb_demux_fifo_arbiter;

  logic        clk = 1'b0;
  logic        reset_L;
  logic [11:0] data_in0, data_in1, data_in2, data_in3;
  logic        valid_in0, valid_in1, valid_in2, valid_in3;
  logic        pop;
  logic [11:0] data_out;
  logic [1:0]  class_out;
  logic        valid_out;
  logic [3:0]  almost_full, fifo_empty, overflow;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [13:0] sb [$];

  always #5 clk = ~clk;

  demux_fifo_arbiter #(.DATA_W(12), .DEPTH(4), .AFULL_TH(3)) dut (
    .clk(clk), .reset_L(reset_L),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .valid_in0(valid_in0), .valid_in1(valid_in1), .valid_in2(valid_in2), .valid_in3(valid_in3),
    .pop(pop), .data_out(data_out), .class_out(class_out), .valid_out(valid_out),
    .almost_full(almost_full), .fifo_empty(fifo_empty), .overflow(overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic expect_word(input logic [11:0] d, input logic [1:0] c);
    sb.push_back({d, c});
  endtask

  task automatic wait_drain;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      tick;
    end
    tick;
    tick;
    chk("drain_empty", sb.size(), 0);
  endtask

  // Monitor: a word is consumed at the next edge when valid_out && pop.
  always @(negedge clk) begin
    if (reset_L === 1'b1 && valid_out === 1'b1 && pop === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word actual=%0h/%0d required=none t=%0t", data_out, class_out, $time);
      end else begin
        logic [13:0] e;
        e = sb.pop_front();
        if ({data_out, class_out} !== e) begin
          failures++;
          $display("FAIL out_word actual=%0h/%0d required=%0h/%0d t=%0t",
                   data_out, class_out, e[13:2], e[1:0], $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset_L = 1'b0; pop = 1'b0;
    data_in0 = 12'h5A5; data_in1 = '0; data_in2 = '0; data_in3 = '0;
    valid_in0 = 1'b1; valid_in1 = 1'b0; valid_in2 = 1'b0; valid_in3 = 1'b0;

    // Reset held with a push request present
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_valid", valid_out, 0);
      chk("rst_empty", fifo_empty, 4'hF);
      chk("rst_ovf", overflow, 0);
      chk("rst_afull", almost_full, 0);
    end
    valid_in0 = 1'b0;
    reset_L   = 1'b1;
    tick; tick;
    chk("rst_nothing_stored", fifo_empty, 4'hF);
    chk("rst_no_output", valid_out, 0);

    // Single word: 2-edge latency, then stage empties
    data_in0 = 12'h001; valid_in0 = 1'b1; pop = 1'b1;
    expect_word(12'h001, 2'd0);
    tick;
    valid_in0 = 1'b0;
    chk("single_not_yet", valid_out, 0);
    tick;
    chk("single_valid", valid_out, 1);
    chk("single_data", data_out, 12'h001);
    chk("single_class", class_out, 0);
    tick;
    chk("single_done", valid_out, 0);

    // Four-class burst from fresh reset (last_grant=3 -> class 0 first)
    reset_L = 1'b0; #1; reset_L = 1'b1;
    data_in0 = 12'd1; data_in1 = 12'd2; data_in2 = 12'd3; data_in3 = 12'd4;
    {valid_in3, valid_in2, valid_in1, valid_in0} = 4'hF;
    for (int c = 0; c < 4; c++) expect_word(12'(c + 1), 2'(c));
    tick;
    {valid_in3, valid_in2, valid_in1, valid_in0} = 4'h0;
    for (int c = 0; c < 4; c++) begin
      tick;
      chk("burst_valid", valid_out, 1);
      chk("burst_class", class_out, c);
    end
    tick;
    chk("burst_end", valid_out, 0);

    // Round-robin between FIFOs 1 and 3
    for (int i = 0; i < 3; i++) begin
      expect_word(12'h011 + 12'(i), 2'd1);
      expect_word(12'h031 + 12'(i), 2'd3);
    end
    for (int i = 0; i < 3; i++) begin
      data_in1 = 12'h011 + 12'(i); data_in3 = 12'h031 + 12'(i);
      valid_in1 = 1'b1; valid_in3 = 1'b1;
      tick;
    end
    valid_in1 = 1'b0; valid_in3 = 1'b0;
    wait_drain;

    // Overflow on FIFO 2 behind a held output word (backpressure)
    pop = 1'b0;
    data_in0 = 12'h0AB; valid_in0 = 1'b1;
    expect_word(12'h0AB, 2'd0);
    tick;
    valid_in0 = 1'b0;
    tick;
    chk("bp_valid", valid_out, 1);
    chk("bp_data0", data_out, 12'h0AB);
    for (int i = 0; i < 5; i++) begin
      data_in2 = 12'd10 + 12'(i); valid_in2 = 1'b1;
      if (i < 4) expect_word(12'd10 + 12'(i), 2'd2);
      tick;
      if (i == 1) chk("afull2_below", almost_full[2], 0);
      if (i == 2) chk("afull2_at_th", almost_full[2], 1);
      if (i == 3) chk("ovf2_not_yet", overflow[2], 0);
    end
    valid_in2 = 1'b0;
    chk("ovf2_set", overflow, 4'b0100);
    chk("bp_data_held", data_out, 12'h0AB);
    chk("bp_valid_held", valid_out, 1);
    pop = 1'b1;
    wait_drain;
    chk("ovf2_sticky", overflow, 4'b0100);
    chk("afull_clear", almost_full, 0);

    // Push into a full FIFO 1 while it is being read: word is dropped
    pop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_in1 = 12'h021 + 12'(i); valid_in1 = 1'b1;
      expect_word(12'h021 + 12'(i), 2'd1);
      tick;
    end
    chk("afull1_full", almost_full[1], 1);
    data_in1 = 12'h026; pop = 1'b1;
    tick;
    valid_in1 = 1'b0;
    chk("ovf1_set", overflow, 4'b0110);
    wait_drain;

    // Asynchronous reset mid-cycle while a word is held
    pop = 1'b0;
    data_in3 = 12'h03C; valid_in3 = 1'b1;
    tick; tick;
    valid_in3 = 1'b0;
    tick;
    chk("mid_valid_before", valid_out, 1);
    #1 reset_L = 1'b0;
    sb.delete();
    #1;
    chk("mid_valid_async", valid_out, 0);
    chk("mid_empty_async", fifo_empty, 4'hF);
    chk("mid_ovf_async", overflow, 0);
    chk("mid_data_async", data_out, 0);
    tick;
    reset_L = 1'b1;

    // Push accepted on first edge after release
    data_in1 = 12'h07E; valid_in1 = 1'b1; pop = 1'b1;
    expect_word(12'h07E, 2'd1);
    tick;
    valid_in1 = 1'b0;
    tick;
    chk("post_valid", valid_out, 1);
    chk("post_data", data_out, 12'h07E);
    chk("post_class", class_out, 1);
    wait_drain;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
